// File: rtl/mmu_io_master.sv
// mmu_io_master: Z80-style I/O bus initiator for single transactions and MMU page-map programming.
// Optional readback verification of page-map writes: define MMU_IO_MASTER_VERIFY_EN.
module mmu_io_master #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        map_start,
  input  logic [31:0] map_table,
  input  logic [5:0]  map_clkdiv,
  output logic        map_busy,
  output logic        map_done,
  output logic        map_err,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        mreq_n,
  output logic [7:0]  a07,
  output logic [7:0]  dout,
  output logic        doe,
  input  logic [7:0]  din
);
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;
`ifdef MMU_IO_MASTER_VERIFY_EN
  localparam logic [4:0] LAST = 5'd18;
  localparam logic [4:0] MAP_LAST = 5'd16;
`else
  localparam logic [4:0] LAST = 5'd10;
  localparam logic [4:0] MAP_LAST = 5'd8;
`endif
  localparam logic [2:0] WS_M1 = 3'(WAIT_STATES - 1);
  state_t state, state_nxt;
  logic [4:0]  step, sel;
  logic [31:0] tbl_q;
  logic [5:0]  div_q;
  logic [2:0]  wcnt, n;
  logic [7:0]  rd_q, sq_addr, sq_data, ld_addr, ld_data;
  logic        cur_write, in_map, chk, sq_write, ld_write;
  logic        map_go, cmd_go, seq_next, ld, strobe, last_strobe;
  // sel is the sequence step whose bus cycle would be loaded next
  always_comb begin
    sel = (state == S_IDLE) ? 5'd0 : step + 5'd1;
`ifdef MMU_IO_MASTER_VERIFY_EN
    {n, chk} = 4'(sel - 5'd1);
`else
    n = 3'(sel - 5'd1);
    chk = 1'b0;
`endif
    in_map = (sel != 5'd0) && (sel <= MAP_LAST);
    sq_write = (sel != 5'd0) && !(in_map && chk);
    sq_addr = (sel == 5'd0) ? 8'hD1 : in_map ? {5'b11011, n} : (sel == LAST - 5'd1) ? 8'hD0 : 8'hD1;
    sq_data = in_map ? {4'h0, tbl_q[{n, 2'b00} +: 4]} : (sel == LAST - 5'd1) ? {2'b00, div_q} : 8'h00;
    map_go = (state == S_IDLE) && map_start && !map_busy;
    cmd_go = (state == S_IDLE) && cmd_valid && !map_go;
    seq_next = (state == S_T3) && map_busy && (step != LAST);
    ld = map_go || cmd_go || seq_next;
    ld_write = cmd_go ? cmd_write : sq_write;
    ld_addr = cmd_go ? cmd_addr : sq_addr;
    ld_data = !ld_write ? 8'h00 : cmd_go ? cmd_wdata : sq_data;
    strobe = (state == S_T2) || (state == S_TW);
    last_strobe = ((state == S_T2) && (WAIT_STATES == 0)) || ((state == S_TW) && (wcnt == WS_M1));
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     state_nxt = (map_go || cmd_go) ? S_T1 : S_IDLE;
      S_T1:       state_nxt = S_T2;
      S_T2, S_TW: state_nxt = last_strobe ? S_T3 : S_TW;
      S_T3:       state_nxt = seq_next ? S_T1 : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end
  assign cmd_ready = (state == S_IDLE);
  assign iorq_n = !strobe;
  assign rd_n = !(strobe && !cur_write);
  assign wr_n = !(strobe && cur_write);
  assign mreq_n = 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      step <= 5'd0;
      tbl_q <= 32'h0;
      div_q <= 6'h0;
      wcnt <= 3'd0;
      cur_write <= 1'b0;
      rd_q <= 8'h00;
      a07 <= 8'h00;
      dout <= 8'h00;
      doe <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      map_busy <= 1'b0;
      map_done <= 1'b0;
    end else begin
      state <= state_nxt;
      rsp_valid <= 1'b0;
      map_done <= 1'b0;
      if (state == S_T2) wcnt <= 3'd0;
      else if (state == S_TW) wcnt <= wcnt + 3'd1;
      if (last_strobe) rd_q <= din;
      if (map_go) begin
        tbl_q <= map_table;
        div_q <= map_clkdiv;
        map_busy <= 1'b1;
        step <= 5'd0;
      end
      if (seq_next) step <= step + 5'd1;
      if (ld) begin
        cur_write <= ld_write;
        a07 <= ld_addr;
        dout <= ld_data;
        doe <= ld_write;
      end else if (state == S_T3) begin
        doe <= 1'b0;
        map_busy <= 1'b0;
        map_done <= map_busy;
        rsp_valid <= !map_busy;
        if (!map_busy) rsp_rdata <= cur_write ? 8'h00 : rd_q;
      end
    end
  end
`ifdef MMU_IO_MASTER_VERIFY_EN
  logic       cur_chk;
  logic [3:0] cur_exp;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_chk <= 1'b0;
      cur_exp <= 4'h0;
      map_err <= 1'b0;
    end else begin
      if (ld) begin
        cur_chk <= !cmd_go && in_map && chk;
        cur_exp <= sq_data[3:0];
      end
      if (map_go) map_err <= 1'b0;
      else if (last_strobe && map_busy && cur_chk && (din[3:0] != cur_exp)) map_err <= 1'b1;
    end
  end
`else
  assign map_err = 1'b0;
`endif
endmodule

// File: tb/tb_mmu_io_master.sv
// tb_mmu_io_master: directed self-checking bench for mmu_io_master with WAIT_STATES = 1.
module tb_mmu_io_master;
`ifdef MMU_IO_MASTER_VERIFY_EN
  localparam int NCYC = 19;
`else
  localparam int NCYC = 11;
`endif
  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, map_start = 1'b0;
  logic [7:0]  cmd_addr = 8'h00, cmd_wdata = 8'h00;
  logic [31:0] map_table = 32'h0;
  logic [5:0]  map_clkdiv = 6'h0;
  logic        cmd_ready, rsp_valid, map_busy, map_done, map_err;
  logic        iorq_n, rd_n, wr_n, mreq_n, doe;
  logic [7:0]  rsp_rdata, a07, dout, din;
  logic        ovr_en = 1'b0;
  logic [7:0]  ovr_addr = 8'h00, ovr_val = 8'h00;
  int tests = 0, fails = 0;
  logic       lg_wr [64];
  logic [7:0] lg_addr [64];
  logic [7:0] lg_data [64];
  int   n_log = 0;
  logic prev_iorq = 1'b1;

  mmu_io_master #(.WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .map_start(map_start),
    .map_table(map_table), .map_clkdiv(map_clkdiv), .map_busy(map_busy),
    .map_done(map_done), .map_err(map_err), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .mreq_n(mreq_n), .a07(a07), .dout(dout), .doe(doe), .din(din)
  );

  always #5 clk = ~clk;
  // responder: ports $D8+n return n unless an override is armed
  assign din = (ovr_en && a07 == ovr_addr) ? ovr_val : {5'b0, a07[2:0]};

  always @(negedge clk) begin
    if (!iorq_n && prev_iorq && n_log < 64) begin
      lg_wr[n_log] <= !wr_n;
      lg_addr[n_log] <= a07;
      lg_data[n_log] <= doe ? dout : 8'h00;
      n_log <= n_log + 1;
    end
    prev_iorq <= iorq_n;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    tests++;
    if ({iorq_n, rd_n, wr_n, mreq_n, doe, cmd_ready, rsp_valid, map_busy, map_done, map_err} !== 10'b1111_0_1_0_0_0_0) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp %b", {iorq_n, rd_n, wr_n, mreq_n, doe, cmd_ready, rsp_valid, map_busy, map_done, map_err}, 10'b1111010000);
    end
    tests++;
    if ({a07, dout, rsp_rdata} !== 24'h0) begin
      fails++;
      $display("FAIL reset_data got %h exp 000000", {a07, dout, rsp_rdata});
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single_write;
    int wr_low = 0, rd_low = 0, doe_cnt = 0, rsp_at = 0, rsp_cnt = 0, mreq_low = 0;
    logic [7:0] rdat = 8'hFF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hD0; cmd_wdata = 8'h07;
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_ready got %b exp 1", cmd_ready); end
    tick;
    cmd_valid = 1'b0;
    tests++;
    if ({a07, dout, doe, iorq_n, cmd_ready} !== {8'hD0, 8'h07, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL wr_t1 got %h/%h/%b%b%b exp d0/07/110", a07, dout, doe, iorq_n, cmd_ready);
    end
    for (int i = 1; i <= 8; i++) begin
      if (!wr_n && !iorq_n) wr_low++;
      if (!rd_n) rd_low++;
      if (!mreq_n) mreq_low++;
      if (doe) doe_cnt++;
      if (rsp_valid) begin rsp_cnt++; rsp_at = i; rdat = rsp_rdata; end
      tick;
    end
    tests++;
    if (wr_low !== 2 || rd_low !== 0 || mreq_low !== 0) begin
      fails++;
      $display("FAIL wr_strobes got wr=%0d rd=%0d mreq=%0d exp 2/0/0", wr_low, rd_low, mreq_low);
    end
    tests++;
    if (doe_cnt !== 4) begin fails++; $display("FAIL wr_doe got %0d exp 4", doe_cnt); end
    tests++;
    if (rsp_at !== 5 || rsp_cnt !== 1 || rdat !== 8'h00) begin
      fails++;
      $display("FAIL wr_rsp got at=%0d cnt=%0d data=%h exp 5/1/00", rsp_at, rsp_cnt, rdat);
    end
  endtask

  task automatic test_single_read;
    int rd_low = 0, wr_low = 0, doe_cnt = 0, rsp_at = 0, rsp_cnt = 0;
    logic [7:0] rdat = 8'h00;
    ovr_en = 1'b1; ovr_addr = 8'hD8; ovr_val = 8'h0A;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'hD8;
    tick;
    cmd_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!rd_n && !iorq_n) rd_low++;
      if (!wr_n) wr_low++;
      if (doe) doe_cnt++;
      if (rsp_valid) begin rsp_cnt++; rsp_at = i; rdat = rsp_rdata; end
      tick;
    end
    ovr_en = 1'b0;
    tests++;
    if (rd_low !== 2 || wr_low !== 0 || doe_cnt !== 0) begin
      fails++;
      $display("FAIL rd_strobes got rd=%0d wr=%0d doe=%0d exp 2/0/0", rd_low, wr_low, doe_cnt);
    end
    tests++;
    if (rsp_at !== 5 || rsp_cnt !== 1 || rdat !== 8'h0A) begin
      fails++;
      $display("FAIL rd_rsp got at=%0d cnt=%0d data=%h exp 5/1/0a", rsp_at, rsp_cnt, rdat);
    end
  endtask

  task automatic test_map;
    int base, done_at = 0, done_cnt = 0, busy_bad = 0, rsp_cnt = 0, ne = 0;
    logic err_at_done = 1'b1, busy_at_done = 1'b1;
    logic       e_wr [32];
    logic [7:0] e_addr [32];
    logic [7:0] e_data [32];
    logic       e_chk [32];
    map_table = 32'h76543210; map_clkdiv = 6'h05;
    e_wr[ne] = 1'b0; e_addr[ne] = 8'hD1; e_data[ne] = 8'h00; e_chk[ne] = 1'b0; ne++;
    for (int k = 0; k < 8; k++) begin
      e_wr[ne] = 1'b1; e_addr[ne] = 8'hD8 + 8'(k); e_data[ne] = 8'(k); e_chk[ne] = 1'b1; ne++;
`ifdef MMU_IO_MASTER_VERIFY_EN
      e_wr[ne] = 1'b0; e_addr[ne] = 8'hD8 + 8'(k); e_data[ne] = 8'h00; e_chk[ne] = 1'b0; ne++;
`endif
    end
    e_wr[ne] = 1'b1; e_addr[ne] = 8'hD0; e_data[ne] = 8'h05; e_chk[ne] = 1'b1; ne++;
    e_wr[ne] = 1'b1; e_addr[ne] = 8'hD1; e_data[ne] = 8'h00; e_chk[ne] = 1'b0; ne++;
    base = n_log;
    map_start = 1'b1;
    tick;
    map_start = 1'b0;
    tests++;
    if (map_busy !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL map_busy_start got busy=%b ready=%b exp 1/0", map_busy, cmd_ready);
    end
    for (int i = 1; i <= NCYC * 4 + 12; i++) begin
      if (map_busy && cmd_ready) busy_bad++;
      if (rsp_valid) rsp_cnt++;
      if (map_done) begin
        done_cnt++;
        if (done_at == 0) begin done_at = i; err_at_done = map_err; busy_at_done = map_busy; end
      end
      map_start = (i == 10);
      tick;
    end
    map_start = 1'b0;
    tests++;
    if (done_at !== NCYC * 4 + 1 || done_cnt !== 1) begin
      fails++;
      $display("FAIL map_done got at=%0d cnt=%0d exp %0d/1", done_at, done_cnt, NCYC * 4 + 1);
    end
    tests++;
    if (busy_at_done !== 1'b0 || err_at_done !== 1'b0 || busy_bad !== 0 || rsp_cnt !== 0) begin
      fails++;
      $display("FAIL map_flags got busy=%b err=%b ready_bad=%0d rsp=%0d exp 0/0/0/0", busy_at_done, err_at_done, busy_bad, rsp_cnt);
    end
    tests++;
    if (n_log - base !== ne) begin fails++; $display("FAIL map_count got %0d exp %0d", n_log - base, ne); end
    for (int j = 0; j < ne; j++) begin
      tests++;
      if (lg_wr[base + j] !== e_wr[j] || lg_addr[base + j] !== e_addr[j] || (e_chk[j] && lg_data[base + j] !== e_data[j])) begin
        fails++;
        $display("FAIL map_cycle%0d got wr=%b addr=%h data=%h exp wr=%b addr=%h data=%h", j,
                 lg_wr[base + j], lg_addr[base + j], lg_data[base + j], e_wr[j], e_addr[j], e_data[j]);
      end
    end
  endtask

  task automatic test_collision;
    int base, done_at = 0, busy_bad = 0, rsp_cnt = 0, rsp_seen = 0;
    logic ready_at_done = 1'b0;
    base = n_log;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hD0; cmd_wdata = 8'h11;
    map_start = 1'b1;
    tick;
    map_start = 1'b0;
    for (int i = 1; i <= NCYC * 4 + 12; i++) begin
      if (map_busy && cmd_ready) busy_bad++;
      if (rsp_valid) rsp_cnt++;
      if (map_done) begin done_at = i; ready_at_done = cmd_ready; break; end
      tick;
    end
    tests++;
    if (done_at !== NCYC * 4 + 1 || ready_at_done !== 1'b1) begin
      fails++;
      $display("FAIL coll_done got at=%0d ready=%b exp %0d/1", done_at, ready_at_done, NCYC * 4 + 1);
    end
    tests++;
    if (busy_bad !== 0 || rsp_cnt !== 0 || lg_wr[base] !== 1'b0 || lg_addr[base] !== 8'hD1) begin
      fails++;
      $display("FAIL coll_map_only got ready_bad=%0d rsp=%0d first=%b/%h exp 0/0/0/d1", busy_bad, rsp_cnt, lg_wr[base], lg_addr[base]);
    end
    tick;
    cmd_valid = 1'b0;
    tests++;
    if ({a07, dout, doe, cmd_ready} !== {8'hD0, 8'h11, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL coll_cmd_t1 got %h/%h/%b%b exp d0/11/10", a07, dout, doe, cmd_ready);
    end
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) rsp_seen++;
      tick;
    end
    tests++;
    if (rsp_seen !== 1 || n_log - base !== NCYC + 1) begin
      fails++;
      $display("FAIL coll_cmd_rsp got rsp=%0d cycles=%0d exp 1/%0d", rsp_seen, n_log - base, NCYC + 1);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hD8; cmd_wdata = 8'h55;
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    tests++;
    if (wr_n !== 1'b0 || iorq_n !== 1'b0) begin fails++; $display("FAIL rst_mid_tw got wr_n=%b iorq_n=%b exp 0/0", wr_n, iorq_n); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tests++;
    if ({iorq_n, rd_n, wr_n, doe, map_busy, cmd_ready} !== 6'b111001) begin
      fails++;
      $display("FAIL rst_mid_bus got %b exp 111001", {iorq_n, rd_n, wr_n, doe, map_busy, cmd_ready});
    end
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || map_done) pulses++;
      tick;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL rst_mid_pulse got %0d exp 0", pulses); end
    map_start = 1'b1;
    tick;
    map_start = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tests++;
    if ({iorq_n, rd_n, wr_n, doe, map_busy, cmd_ready} !== 6'b111001) begin
      fails++;
      $display("FAIL rst_map_bus got %b exp 111001", {iorq_n, rd_n, wr_n, doe, map_busy, cmd_ready});
    end
    pulses = 0;
    for (int i = 0; i < NCYC * 4 + 8; i++) begin
      if (map_done || map_busy) pulses++;
      tick;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL rst_map_done got %0d exp 0", pulses); end
  endtask

`ifdef MMU_IO_MASTER_VERIFY_EN
  task automatic test_verify;
    logic err_at_done = 1'b0;
    int done_at = 0;
    ovr_en = 1'b1; ovr_addr = 8'hDA; ovr_val = 8'h03;
    map_table = 32'h76543210;
    map_start = 1'b1;
    tick;
    map_start = 1'b0;
    for (int i = 1; i <= NCYC * 4 + 8; i++) begin
      if (map_done && done_at == 0) begin done_at = i; err_at_done = map_err; end
      tick;
    end
    tests++;
    if (done_at !== NCYC * 4 + 1 || err_at_done !== 1'b1 || map_err !== 1'b1) begin
      fails++;
      $display("FAIL ver_err got at=%0d err=%b now=%b exp %0d/1/1", done_at, err_at_done, map_err, NCYC * 4 + 1);
    end
    ovr_en = 1'b0;
    map_start = 1'b1;
    tick;
    map_start = 1'b0;
    tests++;
    if (map_err !== 1'b0) begin fails++; $display("FAIL ver_clear got %b exp 0", map_err); end
    for (int i = 0; i < NCYC * 4 + 8; i++) tick;
    tests++;
    if (map_err !== 1'b0 || map_busy !== 1'b0) begin fails++; $display("FAIL ver_clean got err=%b busy=%b exp 0/0", map_err, map_busy); end
  endtask
`endif

  initial begin
    test_reset;
    test_single_write;
    test_single_read;
    test_map;
    test_collision;
    test_reset_mid;
`ifdef MMU_IO_MASTER_VERIFY_EN
    test_verify;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
